stepper_pulse_gen: RTL and testbench

Dual-axis stepper pulse generator directly downstream of the SCARA controller. It latches a move command (step counts plus directions for both joints) on the controller's dataReady strobe. It then emits timed step/direction pulses to both motor drivers concurrently and drives stepperReady back to the controller, so the controller knows when it may issue the next move.

---
 rtl/stepper_pulse_gen.sv | 215 +++++++++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_gen.sv
// Dual-axis stepper pulse generator.
// Latches a move command (per-joint step counts and directions) when the
// controller strobes dataReady. Both joints then step concurrently, one step
// per STEP_PERIOD clocks, after a DIR_SETUP hold that lets the drivers see a
// stable direction. stepperReady tells the controller when the next move may
// be loaded. moveDone pulses for one cycle when a move finishes.
// Every output comes straight from a flop. The step outputs are registered
// from the current period counter, so each pulse trails pc by one clock.

module stepper_pulse_gen #(
    parameter int STEP_PERIOD = 2000,
    parameter int PULSE_WIDTH = 200,
    parameter int DIR_SETUP   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dataReady,
    input  logic [7:0] steps1,
    input  logic [7:0] steps2,
    input  logic       dir1,
    input  logic       dir2,
    output logic       step1Out,
    output logic       step2Out,
    output logic       dir1Out,
    output logic       dir2Out,
    output logic       stepperReady,
    output logic       moveDone,
    output logic [7:0] remaining1,
    output logic [7:0] remaining2
);

    localparam int NUM_AXES = 2;
    localparam int PC_W     = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int SC_W     = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(STEP_PERIOD - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [SC_W-1:0] setup_cnt_reg;
    logic [SC_W-1:0] setup_cnt_next;
    logic            ready_reg;
    logic            ready_next;
    logic            done_reg;
    logic            done_next;

    // Per-axis views of the command inputs and the per-axis state.
    logic [7:0]      steps_in       [NUM_AXES];
    logic            dir_in         [NUM_AXES];
    logic [7:0]      remaining_reg  [NUM_AXES];
    logic [7:0]      remaining_next [NUM_AXES];
    logic            dir_reg        [NUM_AXES];
    logic            dir_next       [NUM_AXES];
    logic            step_reg       [NUM_AXES];
    logic            step_next      [NUM_AXES];

    logic [NUM_AXES-1:0] axis_last;
    logic [NUM_AXES-1:0] axis_zero_in;

    logic load;
    logic period_end;
    logic pulse_phase;
    logic move_empty;
    logic move_last;

    assign steps_in[0] = steps1;
    assign steps_in[1] = steps2;
    assign dir_in[0]   = dir1;
    assign dir_in[1]   = dir2;

    // A command is only accepted while idle; strobes at other times are ignored.
    assign load        = (state_reg == ST_IDLE) && dataReady;

    // The edge at which every nonzero remaining count drops by one.
    assign period_end  = (state_reg == ST_RUN) && enable && (pc_reg == PC_LAST);

    // High-phase of the step waveform within the current period.
    assign pulse_phase = 32'(pc_reg) < 32'(PULSE_WIDTH);

    // Empty moves skip straight to DONE; the last period of a move ends in DONE.
    assign move_empty  = &axis_zero_in;
    assign move_last   = &axis_last;

    // Sequencer state, period counter and direction-setup counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            setup_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            setup_cnt_reg <= setup_cnt_next;
        end
    end

    // Next-state logic; enable low freezes both counters in SETUP and RUN.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        setup_cnt_next = setup_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (dataReady) begin
                    state_next     = move_empty ? ST_DONE : ST_SETUP;
                    setup_cnt_next = '0;
                    pc_next        = '0;
                end
            end
            ST_SETUP: begin
                if (enable) begin
                    if (setup_cnt_reg == SC_LAST) begin
                        state_next = ST_RUN;
                        pc_next    = '0;
                    end else begin
                        setup_cnt_next = setup_cnt_reg + SC_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (pc_reg == PC_LAST) begin
                        pc_next = '0;
                        if (move_last) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        pc_next = pc_reg + PC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs: ready drops on the load edge and returns one cycle
    // after the DONE cycle, so it trails the moveDone pulse by one clock.
    always_comb begin
        ready_next = (state_reg == ST_IDLE) && !dataReady;
        done_next  = (state_reg == ST_DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            done_reg  <= done_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            // Count, direction and pulse for one joint.
            always_comb begin
                remaining_next[gi] = remaining_reg[gi];
                dir_next[gi]       = dir_reg[gi];
                if (load) begin
                    remaining_next[gi] = steps_in[gi];
                    dir_next[gi]       = dir_in[gi];
                end else if (period_end && (remaining_reg[gi] != 8'd0)) begin
                    remaining_next[gi] = remaining_reg[gi] - 8'd1;
                end
                // A joint with no steps left stays quiet for the rest of the move.
                step_next[gi] = (state_reg == ST_RUN) && enable && pulse_phase &&
                                (remaining_reg[gi] != 8'd0);
            end

            assign axis_last[gi]    = remaining_reg[gi] <= 8'd1;
            assign axis_zero_in[gi] = steps_in[gi] == 8'd0;

            // Per-joint registers; reset aborts any move in progress.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    remaining_reg[gi] <= 8'd0;
                    dir_reg[gi]       <= 1'b0;
                    step_reg[gi]      <= 1'b0;
                end else begin
                    remaining_reg[gi] <= remaining_next[gi];
                    dir_reg[gi]       <= dir_next[gi];
                    step_reg[gi]      <= step_next[gi];
                end
            end
        end
    endgenerate

    assign step1Out     = step_reg[0];
    assign step2Out     = step_reg[1];
    assign dir1Out      = dir_reg[0];
    assign dir2Out      = dir_reg[1];
    assign remaining1   = remaining_reg[0];
    assign remaining2   = remaining_reg[1];
    assign stepperReady = ready_reg;
    assign moveDone     = done_reg;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with a small period so whole moves
// fit in a short run: STEP_PERIOD=10, PULSE_WIDTH=2, DIR_SETUP=4.
// Expected timings: first pulse 5 clocks after the load edge, moveDone
// 4 + steps*10 + 1 clocks after it, stepperReady one clock later.

module tb_stepper_pulse_gen;

    localparam int SP = 10;
    localparam int PW = 2;
    localparam int DS = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       dataReady;
    logic [7:0] steps1;
    logic [7:0] steps2;
    logic       dir1;
    logic       dir2;
    logic       step1Out;
    logic       step2Out;
    logic       dir1Out;
    logic       dir2Out;
    logic       stepperReady;
    logic       moveDone;
    logic [7:0] remaining1;
    logic [7:0] remaining2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Pulse monitor state (written only by the monitor process).
    int rise1_q[$];
    int rise2_q[$];
    int high1  = 0;
    int high2  = 0;
    logic p1   = 1'b0;
    logic p2   = 1'b0;

    stepper_pulse_gen #(
        .STEP_PERIOD(SP),
        .PULSE_WIDTH(PW),
        .DIR_SETUP  (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .dataReady   (dataReady),
        .steps1      (steps1),
        .steps2      (steps2),
        .dir1        (dir1),
        .dir2        (dir2),
        .step1Out    (step1Out),
        .step2Out    (step2Out),
        .dir1Out     (dir1Out),
        .dir2Out     (dir2Out),
        .stepperReady(stepperReady),
        .moveDone    (moveDone),
        .remaining1  (remaining1),
        .remaining2  (remaining2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Record rising edges and high cycles of both step outputs.
    always @(negedge clk) begin
        if (step1Out && !p1) rise1_q.push_back(cyc);
        if (step2Out && !p2) rise2_q.push_back(cyc);
        if (step1Out) high1 = high1 + 1;
        if (step2Out) high2 = high2 + 1;
        p1 = step1Out;
        p2 = step2Out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a command for one clock; returns the index of the load edge.
    task automatic load(input logic [7:0] s1, input logic [7:0] s2,
                        input logic d1, input logic d2, output int lc);
        @(negedge clk);
        steps1    = s1;
        steps2    = s2;
        dir1      = d1;
        dir2      = d2;
        dataReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dataReady = 1'b0;
        lc = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Wait (bounded) for moveDone; reports the cycle it was seen high.
    task automatic wait_done(input int max_cycles, output int at, output logic seen);
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (moveDone) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    initial begin
        int   lc;
        int   dc;
        logic seen;
        int   b1;
        int   b2;
        int   h1;
        int   h2;

        reset     = 1'b1;
        enable    = 1'b1;
        dataReady = 1'b0;
        steps1    = 8'd0;
        steps2    = 8'd0;
        dir1      = 1'b0;
        dir2      = 1'b0;
        #2 reset  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", stepperReady, 1);
        check("rst_step1", step1Out, 0);
        check("rst_step2", step2Out, 0);
        check("rst_done",  moveDone, 0);
        check("rst_rem1",  remaining1, 0);
        check("rst_rem2",  remaining2, 0);
        check("rst_dir1",  dir1Out, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1 + 3: 3/5 step move, with an ignored load strobe mid-move.
        load(8'd3, 8'd5, 1'b1, 1'b0, lc);
        b1 = rise1_q.size(); b2 = rise2_q.size(); h1 = high1; h2 = high2;
        check("s1_dir1", dir1Out, 1);
        check("s1_dir2", dir2Out, 0);
        check("s1_ready_low", stepperReady, 0);
        check("s1_rem1", remaining1, 3);
        check("s1_rem2", remaining2, 5);
        wait_until(lc + 19);
        steps1 = 8'd9; dir1 = 1'b0; dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        check("s3_rem1_kept", remaining1, 2);
        check("s3_rem2_kept", remaining2, 4);
        check("s3_dir1_kept", dir1Out, 1);
        wait_done(200, dc, seen);
        check("s1_done_seen", seen, 1);
        check("s1_done_lat", dc - lc, 55);
        check("s1_ready_at_done", stepperReady, 0);
        @(negedge clk);
        check("s1_done_width", moveDone, 0);
        check("s1_ready_after", stepperReady, 1);
        check("s1_rise1_cnt", rise1_q.size() - b1, 3);
        check("s1_rise2_cnt", rise2_q.size() - b2, 5);
        check("s1_first_lat", rise1_q[b1] - lc, DS + 1);
        check("s1_first2_lat", rise2_q[b2] - lc, DS + 1);
        check("s1_spacing", rise1_q[b1 + 1] - rise1_q[b1], SP);
        check("s1_high1", high1 - h1, 3 * PW);
        check("s1_high2", high2 - h2, 5 * PW);
        check("s1_rem1_end", remaining1, 0);

        // Scenario 2: empty move.
        load(8'd0, 8'd0, 1'b0, 1'b0, lc);
        b1 = rise1_q.size(); b2 = rise2_q.size();
        check("s2_ready_low", stepperReady, 0);
        check("s2_done_early", moveDone, 0);
        @(negedge clk);
        check("s2_done", moveDone, 1);
        check("s2_ready_at_done", stepperReady, 0);
        @(negedge clk);
        check("s2_done_off", moveDone, 0);
        check("s2_ready", stepperReady, 1);
        repeat (20) @(negedge clk);
        check("s2_no_pulse1", rise1_q.size() - b1, 0);
        check("s2_no_pulse2", rise2_q.size() - b2, 0);

        // Scenario 4: pause for 7 clocks during the second step1 pulse.
        load(8'd3, 8'd5, 1'b1, 1'b0, lc);
        h1 = high1; h2 = high2;
        wait_until(lc + 15);
        check("s4_pulse2_high", step1Out, 1);
        enable = 1'b0;
        wait_until(lc + 16);
        check("s4_truncated", step1Out, 0);
        wait_until(lc + 22);
        check("s4_rem1_frozen", remaining1, 2);
        check("s4_rem2_frozen", remaining2, 4);
        check("s4_step2_low", step2Out, 0);
        enable = 1'b1;
        wait_until(lc + 23);
        check("s4_resumed", step1Out, 1);
        wait_done(200, dc, seen);
        check("s4_done_seen", seen, 1);
        check("s4_done_lat", dc - lc, 62);
        check("s4_high1", high1 - h1, 3 * PW);
        check("s4_high2", high2 - h2, 5 * PW);
        @(negedge clk);

        // Scenario 5: asynchronous reset mid-RUN.
        load(8'd3, 8'd5, 1'b1, 1'b1, lc);
        wait_until(lc + 15);
        #2 reset = 1'b0;
        #1;
        check("s5_step1", step1Out, 0);
        check("s5_ready", stepperReady, 1);
        check("s5_rem1", remaining1, 0);
        check("s5_rem2", remaining2, 0);
        check("s5_dir2", dir2Out, 0);
        @(negedge clk);
        reset = 1'b1;
        b1 = rise1_q.size(); b2 = rise2_q.size();
        repeat (40) @(negedge clk);
        check("s5_no_pulse1", rise1_q.size() - b1, 0);
        check("s5_no_pulse2", rise2_q.size() - b2, 0);
        check("s5_ready_idle", stepperReady, 1);

        // Scenario 6: maximum count on one axis, single step on the other.
        load(8'd255, 8'd1, 1'b0, 1'b1, lc);
        b1 = rise1_q.size(); b2 = rise2_q.size();
        check("s6_dir2", dir2Out, 1);
        check("s6_rem1", remaining1, 255);
        wait_until(lc + 15);
        check("s6_rem2_zero", remaining2, 0);
        check("s6_rem1_254", remaining1, 254);
        wait_until(lc + 100);
        check("s6_rem2_stays", remaining2, 0);
        wait_done(3000, dc, seen);
        check("s6_done_seen", seen, 1);
        check("s6_done_lat", dc - lc, DS + 255 * SP + 1);
        check("s6_rise1_cnt", rise1_q.size() - b1, 255);
        check("s6_rise2_cnt", rise2_q.size() - b2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
